// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush/forwarding control and MEM-stage memory-wait FSM for
//            the 5-stage RV32I pipeline. Optional stall-cycle counter is
//            built when HAZARD_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic        load_e,
  input  logic        pc_src_e,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_m,
  input  logic        mem_access_m,
  input  logic        mem_ready,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_w,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        mem_req,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_wcnt;
  logic       r_mem_err;

  logic       w_lw_stall;
  logic       w_mem_wait;
  logic       w_wait_expired;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wm,
    input logic [4:0] rdw,
    input logic       ww
  );
    if (wm && (rdm != 5'd0) && (rdm == rs))
      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  assign w_lw_stall     = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign w_wait_expired = (r_wcnt == C_TIMEOUT);

  assign w_mem_wait = ((r_state == S_IDLE) && mem_access_m && !mem_ready) ||
                      ((r_state == S_WAIT) && !mem_ready && !w_wait_expired);

  assign mem_req = (r_state == S_WAIT) || mem_access_m;
  assign mem_err = r_mem_err;

  assign stall_e = w_mem_wait;
  assign stall_m = w_mem_wait;
  assign flush_w = w_mem_wait;
  assign stall_f = w_mem_wait || w_lw_stall;
  assign stall_d = w_mem_wait || w_lw_stall;
  // EX is frozen during a memory wait, so branch/load-use bubbles wait for release
  assign flush_d = pc_src_e && !w_mem_wait;
  assign flush_e = (w_lw_stall || pc_src_e) && !w_mem_wait;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_access_m && !mem_ready) begin
            r_state <= S_WAIT;
            r_wcnt  <= 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            r_state <= S_IDLE;
          end else if (w_wait_expired) begin
            r_mem_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      r_stall_cnt <= 32'd0;
    else if (stall_f && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        load_e, pc_src_e, reg_write_m, mem_access_m, mem_ready, reg_write_w;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        mem_req, mem_err;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_access_m(mem_access_m), .mem_ready(mem_ready), .rd_w(rd_w),
    .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_req(mem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_access_m = 0; mem_ready = 0;
  endtask

  // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,mem_req}
  function automatic logic [7:0] ctl();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_req};
  endfunction

  initial begin
    clear_inputs();
    Rst_n = 1'b0;
    #23;
    chk("reset_ctl", 32'(ctl()), 32'h00);
    chk("reset_fwd", {28'd0, fwd_a_e, fwd_b_e}, 32'h0);
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    Rst_n = 1'b1;
    step();

    // forwarding priority and x0 handling
    rs1_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1; #1;
    chk("fwd_a_mem", 32'(fwd_a_e), 32'd2);
    rd_m = 0; #1;
    chk("fwd_a_wb", 32'(fwd_a_e), 32'd1);
    rs2_e = 7; rd_w = 7; #1;
    chk("fwd_b_wb", 32'(fwd_b_e), 32'd1);
    chk("fwd_a_none", 32'(fwd_a_e), 32'd0);
    reg_write_w = 0; #1;
    chk("fwd_b_nowrite", 32'(fwd_b_e), 32'd0);
    rd_m = 7; reg_write_m = 1; rd_w = 0; rs2_e = 0; rs1_e = 7; #1;
    chk("fwd_a_mem2", 32'(fwd_a_e), 32'd2);
    clear_inputs();

    // load-use
    step();
    load_e = 1; rd_e = 3; rs2_d = 3; #1;
    chk("lw_ctl", 32'(ctl()), 32'b1100_0100);
    step();
    load_e = 0; #1;
    chk("lw_release", 32'(ctl()), 32'h00);
    load_e = 1; rd_e = 0; rs1_d = 0; rs2_d = 0; #1;
    chk("lw_x0", 32'(ctl()), 32'h00);
    clear_inputs();

    // simultaneous load-use and taken branch
    load_e = 1; rd_e = 9; rs1_d = 9; pc_src_e = 1; #1;
    chk("lw_branch", 32'(ctl()), 32'b1100_1100);
    clear_inputs();

    // zero-wait access
    step();
    mem_access_m = 1; mem_ready = 1; #1;
    chk("zero_wait", 32'(ctl()), 32'b0000_0001);
    step();

    // 3-wait access with branch pending; ready on 4th cycle
    mem_ready = 0; pc_src_e = 1; #1;
    chk("wait_c1", 32'(ctl()), 32'b1111_0011);
    step();
    chk("wait_c2", 32'(ctl()), 32'b1111_0011);
    step();
    chk("wait_c3", 32'(ctl()), 32'b1111_0011);
    step();
    mem_ready = 1; #1;
    chk("wait_ready", 32'(ctl()), 32'b0000_1101);
    step();
    // back-to-back: next access stalls in the very first cycle
    pc_src_e = 0; mem_ready = 0; #1;
    chk("b2b_c1", 32'(ctl()), 32'b1111_0011);
    step();
    mem_ready = 1; #1;
    chk("b2b_ready", 32'(ctl()), 32'b0000_0001);
    step();
    clear_inputs(); #1;
    chk("idle_after", 32'(ctl()), 32'h00);

    // timeout with MEM_TIMEOUT = 4
    step();
    mem_access_m = 1; mem_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("to_stall%0d", i), 32'({stall_m, mem_req}), 32'b11);
      step();
    end
    chk("to_final", 32'({stall_m, mem_req, mem_err}), 32'b010);
    step();
    mem_access_m = 0; #1;
    chk("to_err", 32'({mem_err, mem_req, stall_m}), 32'b100);
    step();
    chk("to_sticky", 32'(mem_err), 32'd1);
    // access still honoured after error
    mem_access_m = 1; mem_ready = 0; #1;
    chk("after_err", 32'({stall_m, mem_req}), 32'b11);
    step();
    step();
    chk("mid_wait_req", 32'(mem_req), 32'd1);

    // asynchronous reset mid-WAIT
    #2;
    Rst_n = 0; mem_access_m = 0; #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    #3;
    Rst_n = 1;
    clear_inputs();
    step();

    // five stall cycles
    load_e = 1; rd_e = 4; rs1_d = 4;
    for (int i = 0; i < 5; i++) step();
    clear_inputs(); #1;
`ifdef HAZARD_PERF_EN
    chk("perf_cnt", stall_cnt, 32'd5);
`else
    chk("perf_cnt", stall_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
